// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory sequencer.
package dmem_access_ctrl_pkg;

  // State encodings for the access FSM
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Cycles allowed in ACCESS without an ack before the access is aborted
  localparam int DEFAULT_DMEM_TIMEOUT = 15;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_DONE   = ST_DONE
  } dmem_state_e;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Clearable cycle counter with terminal-count detect for the access timeout.
// expire_o fires in the TIMEOUT-th enabled cycle, i.e. the cycle in which the
// count would reach TIMEOUT.
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int              CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise advance while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory sequencer: turns a one-cycle MemRead/MemWrite into a
// held req/ack transaction, stalls the pipeline until completion, aborts on
// timeout and counts stall cycles.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_DMEM_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [31:0]       stall_cycles_o
);

  dmem_state_e       state_q;
  logic              req_q, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              mem_op, expire, stall;

  assign mem_op = MemRead_i | MemWrite_i;

  // Combinational so the pipeline freezes in the same cycle the request shows up
  assign stall = !rst_i && (((state_q == S_IDLE) && mem_op) || (state_q == S_ACCESS));

  // Counter is held clear while idle, so it starts from zero on entering ACCESS
  dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_q == S_IDLE),
    .en_i    (state_q == S_ACCESS),
    .expire_o(expire)
  );

  // Access FSM with registered request, latched command and load result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            state_q <= S_ACCESS;
            req_q   <= 1'b1;
            we_q    <= MemWrite_i;  // write wins when both are raised
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
          end
        end
        S_ACCESS: begin
          // ack beats a coinciding timeout
          if (mem_ack_i) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            if (!we_q) rdata_q <= mem_rdata_i;
          end else if (expire) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            if (!we_q) rdata_q <= '0;
          end
        end
        // EX/MEM still shows the finished instruction here; ignore it
        S_DONE:  state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stall_cnt_d = stall_cnt_q + 32'd1;

  // Performance counter of stalled cycles, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i)      stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_d;
  end

  assign mem_req_o      = req_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign stall_o        = stall;
  assign rdata_o        = rdata_q;
  assign err_o          = err_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed table, multi-cycle corner
// sequences and randomized transactions against a transaction-level model.
module tb_dmem_access_ctrl;

  localparam int T = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] stall_cycles_o;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;          // ack after k ACCESS cycles; >= T means never
    logic [31:0] mrd;        // data memory returns with the ack
    int          exp_req;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [6];

  // Model state: load result, sticky error, running stall total
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_stall;

  // One transaction: request in an IDLE cycle, memory acks after k req cycles.
  // Returns after sampling the DONE cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int k, input logic [31:0] rdat,
                         output int req_n, output int stall_n,
                         output logic lat_ok, output logic done);
    req_n = 0; stall_n = 0; lat_ok = 1'b1; done = 1'b0;
    @(posedge clk_i); #1;
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
    #1;
    if (stall_o) stall_n++;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk_i); #1;
      MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = $urandom; wdata_i = $urandom;
      if (mem_req_o) begin
        if (mem_we_o !== wr || mem_addr_o !== a || mem_wdata_o !== wd) lat_ok = 1'b0;
        mem_ack_i   = (req_n == k);
        mem_rdata_i = (req_n == k) ? rdat : $urandom;
        req_n++;
      end else begin
        // DONE: a stray ack here must be ignored
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        done = 1'b1;
      end
      #1;
      if (stall_o) stall_n++;
    end
  endtask

  initial begin
    int          req_n, stall_n, rises, last, stall_lo, gap_ok;
    logic        lat_ok, done, prev;
    logic        rd, wr;
    int          k, e_req, e_stall;
    logic [31:0] a, wd, rdat;

    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;

    //            rd    wr    addr          wdata         k   mrd           req stall rdata        err
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 3, 32'hDEAD_BEEF,  4,  5, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 0, 32'hCAFE_F00D,  1,  2, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0090, 32'h0000_0001, 14, 32'h7777_8888, 15, 16, 32'h7777_8888, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_00C0, 32'h0000_0002, 99, 32'h9999_9999, 15, 16, 32'h0000_0000, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0003, 5, 32'hA5A5_0001,  6,  7, 32'hA5A5_0001, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_0140, 32'h55AA_55AA, 2, 32'h1111_2222,  3,  4, 32'hA5A5_0001, 1'b1};

    // Reset state; stall must stay low under reset even with a request present
    repeat (3) @(posedge clk_i);
    #1;
    MemRead_i = 1'b1;
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_stallcnt", stall_cycles_o, 32'd0);
    MemRead_i = 1'b0; rst_i = 1'b0;
    m_rdata = '0; m_err = 1'b0; m_stall = '0;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].k, tbl[i].mrd,
              req_n, stall_n, lat_ok, done);
      m_stall += 32'(tbl[i].exp_stall);
      chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_req", i), 32'(req_n), 32'(tbl[i].exp_req));
      chk($sformatf("v%0d_stall", i), 32'(stall_n), 32'(tbl[i].exp_stall));
      chk($sformatf("v%0d_latch", i), 32'(lat_ok), 32'd1);
      chk($sformatf("v%0d_rdata", i), rdata_o, tbl[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_stallcnt", i), stall_cycles_o, m_stall);
      chk($sformatf("v%0d_done_nostall", i), 32'(stall_o), 32'd0);
    end
    m_rdata = tbl[5].exp_rdata; m_err = tbl[5].exp_err;

    // Request held through DONE: one transaction per IDLE visit, 3-cycle spacing
    prev = 1'b0; rises = 0; last = -1; stall_lo = 0; gap_ok = 1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk_i); #1;
      MemRead_i = 1'b1; addr_i = 32'h200; mem_ack_i = mem_req_o; mem_rdata_i = 32'h0BAD_0000 + 32'(c);
      #1;
      if (mem_req_o && !prev) begin
        if (last >= 0 && c - last != 3) gap_ok = 0;
        last = c; rises++;
      end
      prev = mem_req_o;
      if (!stall_o) stall_lo++;
    end
    @(posedge clk_i); #1;
    MemRead_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    m_stall += 32'd6;
    m_rdata = 32'h0BAD_0007;  // third ack issued in cycle 7
    chk("held_rises", 32'(rises), 32'd3);
    chk("held_spacing", 32'(gap_ok), 32'd1);
    chk("held_stall_low", 32'(stall_lo), 32'd3);
    chk("held_stallcnt", stall_cycles_o, m_stall);
    chk("held_rdata", rdata_o, m_rdata);

    // Randomized transactions against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      k = int'($urandom_range(0, T + 2));
      a = $urandom; wd = $urandom; rdat = $urandom;
      run_txn(rd, wr, a, wd, k, rdat, req_n, stall_n, lat_ok, done);
      if (k < T) begin
        e_req = k + 1;
        if (!wr) m_rdata = rdat;
      end else begin
        e_req = T;
        m_err = 1'b1;
        if (!wr) m_rdata = '0;
      end
      e_stall = e_req + 1;
      m_stall += 32'(e_stall);
      chk($sformatf("r%0d_req", n), 32'(req_n), 32'(e_req));
      chk($sformatf("r%0d_stall", n), 32'(stall_n), 32'(e_stall));
      chk($sformatf("r%0d_latch", n), 32'(lat_ok), 32'd1);
      chk($sformatf("r%0d_rdata", n), rdata_o, m_rdata);
      chk($sformatf("r%0d_err", n), 32'(err_o), 32'(m_err));
      chk($sformatf("r%0d_stallcnt", n), stall_cycles_o, m_stall);
      // Idle gap with stray acks that must not disturb anything
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        @(posedge clk_i); #1;
        mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
      end
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    #1;
    chk("rand_idle_rdata", rdata_o, m_rdata);
    chk("rand_idle_stallcnt", stall_cycles_o, m_stall);

    // Reset asserted on the 2nd ACCESS cycle, then a late ack
    MemRead_i = 1'b1; addr_i = 32'h300;          // IDLE cycle with request
    @(posedge clk_i); #1;
    MemRead_i = 1'b0;                            // 1st ACCESS
    @(posedge clk_i); #1;
    rst_i = 1'b1;                                // 2nd ACCESS
    #1;
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    chk("mid_rst_req", 32'(mem_req_o), 32'd0);
    chk("mid_rst_addr", mem_addr_o, 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    chk("mid_rst_rdata", rdata_o, 32'd0);
    chk("mid_rst_stallcnt", stall_cycles_o, 32'd0);
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    chk("mid_rst_idle_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    #1;
    chk("late_ack_rdata", rdata_o, 32'd0);
    chk("late_ack_req", 32'(mem_req_o), 32'd0);
    chk("late_ack_stall", 32'(stall_o), 32'd0);
    chk("late_ack_stallcnt", stall_cycles_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for a multi-cycle data memory in the 5-stage pipeline's MEM stage. It converts a single-cycle MemRead/MemWrite from the EX/MEM register into a held request/acknowledge transaction toward data memory. It raises a global pipeline stall until the access completes, and returns the read data. It also enforces an access timeout and counts stall cycles for performance reporting.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles in ACCESS without ack before abort (≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- MemRead_i  in  1  EX/MEM read request
- MemWrite_i  in  1  EX/MEM write request
- addr_i  in  ADDR_W  access address
- wdata_i  in  DATA_W  store data
- mem_req_o  out  1  request to data memory, held until ack
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched store data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- stall_o  out  1  freeze PC and all pipeline registers
- rdata_o  out  DATA_W  load result to MEM/WB
- err_o  out  1  sticky timeout flag
- stall_cycles_o  out  32  count of cycles with stall_o=1, wraps

## Operation
FSM states are IDLE, ACCESS, DONE.
- IDLE, MemRead_i|MemWrite_i=1:
  - Latch addr_i, wdata_i, and we=MemWrite_i.
  - Go to ACCESS and clear the timeout counter.
  - If both read and write are high, the write wins and rdata_o is not updated.
- ACCESS:
  - mem_req_o=1; mem_we_o, mem_addr_o and mem_wdata_o are stable.
  - Counter increments each cycle.
  - mem_ack_i=1: capture mem_rdata_i into rdata_o if read, then go to DONE.
  - Counter reaches TIMEOUT with no ack: set err_o, set rdata_o=0 if read, then go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and err_o is unchanged.
- DONE:
  - mem_req_o=0 and stall_o=0, so the pipeline advances the completed instruction.
  - MemRead_i/MemWrite_i are ignored, since they still show the same instruction.
  - Go to IDLE unconditionally.
- stall_o = !rst_i && ((IDEL-free form: state==IDLE && (MemRead_i|MemWrite_i)) || state==ACCESS). It is combinational, so the pipeline freezes in the same cycle the request appears.
- mem_ack_i is ignored in IDLE and DONE.
- stall_cycles_o increments on every cycle where stall_o=1 and wraps 2^32−1→0.
- err_o is cleared only by reset.
- rdata_o holds its value until the next read completion or abort.

## Timing
- Reset values: state=IDLE, and every registered output is 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, err_o, stall_cycles_o). stall_o=0 while rst_i=1.
- Request seen in IDLE at cycle t:
  - mem_req_o=1 from t+1.
  - Ack at t+1+k (k≥0): DONE at t+2+k, with rdata_o valid from t+2+k.
  - stall_o is high for exactly k+2 cycles (t..t+1+k).
- Timeout: ACCESS lasts TIMEOUT cycles, so stall_o is high for TIMEOUT+1 cycles. err_o=1 from DONE onward.
- Back-to-back accesses: the minimum spacing between mem_req_o rising edges is 3 cycles (ACCESS, DONE, IDLE).
- Reset mid-ACCESS: state returns to IDLE and mem_req_o=0 in the next cycle. A late ack is ignored.

## Structure
- Shared pipeline package holds the state encoding localparams (IDLE/ACCESS/DONE) and DEFAULT_DMEM_TIMEOUT.
- One sub-module, dmem_timeout_cnt, holds the clearable counter and the terminal-count compare against TIMEOUT. It uses a $clog2(TIMEOUT+1)-bit counter.
- The FSM, latches and stall counter live in the top module.

## Test plan
- Read at addr 0x40, ack after k=3 cycles with rdata 0xDEADBEEF:
  - stall_o high for 5 cycles.
  - rdata_o=0xDEADBEEF in DONE.
  - mem_we_o=0.
  - stall_cycles_o=5.
- Write 0x12345678 to 0x80, ack with k=0:
  - mem_we_o=1 with stable addr/wdata for 1 cycle.
  - stall high for 2 cycles.
  - rdata_o unchanged.
- No ack, TIMEOUT=15:
  - mem_req_o high for 15 cycles, then drops.
  - err_o=1, rdata_o=0.
  - stall high for 16 cycles.
  - err_o persists across a subsequent successful read.
- Request held high through DONE:
  - Exactly one transaction is issued.
  - The next request starts only after IDLE, giving a 3-cycle req spacing.
- rst_i asserted on the 2nd ACCESS cycle:
  - Next cycle all outputs are 0 and state is IDLE.
  - A later stray ack produces no capture.
- MemRead_i=MemWrite_i=1: a write is issued and rdata_o is unchanged.
